// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR and trap unit: CSR addresses,
// interrupt cause codes, the CSR operation encoding and bit positions.
package csr_pkg;

    // CSR addresses implemented by the unit
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

    // Interrupt cause codes (the interrupt flag bit is added separately)
    localparam logic [4:0] CAUSE_MTI       = 5'd7;
    localparam logic [4:0] CAUSE_MEI       = 5'd11;
    localparam logic [4:0] CAUSE_PLAT_BASE = 5'd16;

    // mstatus bit positions
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LSB  = 11;

    // mip / mie bit positions
    localparam int MIP_MTIP_BIT = 7;
    localparam int MIP_MEIP_BIT = 11;
    localparam int MIP_PLAT_LSB = 16;

    // CSR access kinds as presented on csr_op
    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_e;

    // Combine the current CSR view with the operand according to the access kind
    function automatic logic [31:0] csr_apply(input csr_op_e op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] operand);
        logic [31:0] result;
        result = old_val;
        case (op)
            CSR_OP_WRITE: result = operand;
            CSR_OP_SET:   result = old_val | operand;
            CSR_OP_CLEAR: result = old_val & ~operand;
            default:      result = old_val;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/csr_trap_unit_irq_arbiter.sv
// Fixed-priority interrupt selector: MEI first, then MTI, then platform lines
// with the lowest index winning.
module csr_irq_arbiter
    import csr_pkg::*;
#(
    parameter int NUM_PLAT_IRQ = 4
) (
    // bit 0 = MTI, bit 1 = MEI, bits 2.. = platform lines 0..NUM_PLAT_IRQ-1
    input  logic [NUM_PLAT_IRQ+1:0] pending,
    output logic                    valid,
    output logic [4:0]              code
);

    // Pick the highest-priority pending source; the platform loop runs from the top index down so the lowest index is the last assignment and therefore wins
    always_comb begin
        valid = 1'b0;
        code  = 5'd0;
        if (pending[1]) begin
            valid = 1'b1;
            code  = CAUSE_MEI;
        end else if (pending[0]) begin
            valid = 1'b1;
            code  = CAUSE_MTI;
        end else begin
            for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
                if (pending[2+i]) begin
                    valid = 1'b1;
                    code  = CAUSE_PLAT_BASE + 5'(i);
                end
            end
        end
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with interrupt trap entry and mret handling.
// Reads are combinational; writes, trap entry and mret update state at the
// next clock edge. Trap entry and mret take precedence over CSR writes to mstatus.
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int NUM_PLAT_IRQ = 4,
    parameter bit VECTORED_EN  = 1'b1,
    parameter bit HAS_MCYCLE   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              csr_op,
    input  logic [11:0]             csr_addr,
    input  logic [31:0]             csr_wdata,
    output logic [31:0]             csr_rdata,
    output logic                    csr_illegal,
    input  logic [31:0]             pc,
    input  logic                    is_mret,
    input  logic                    trap_ready,
    input  logic                    mtip,
    input  logic                    meip,
    input  logic [NUM_PLAT_IRQ-1:0] plat_irq,
    output logic                    redirect,
    output logic [31:0]             redirect_pc,
    output logic                    trap_taken
);

    localparam logic [31:0] PLAT_MASK  = ((32'h1 << NUM_PLAT_IRQ) - 32'h1) << MIP_PLAT_LSB;
    localparam logic [31:0] MIE_MASK   = 32'h0000_0880 | PLAT_MASK;
    localparam logic [31:0] MTVEC_MASK = VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;
    localparam logic [31:0] MEPC_MASK  = 32'hFFFF_FFFC;

    // Architectural state
    logic                    mstatus_mie_q, mstatus_mie_d;
    logic                    mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0]             mie_q, mie_d;
    logic [31:0]             mtvec_q, mtvec_d;
    logic [31:0]             mscratch_q, mscratch_d;
    logic [31:0]             mepc_q, mepc_d;
    logic [31:0]             mcause_q, mcause_d;
    logic [63:0]             mcycle_q, mcycle_d;
    logic                    mtip_q, mtip_d;
    logic                    meip_q, meip_d;
    logic [NUM_PLAT_IRQ-1:0] plat_q, plat_d;

    // Decoded access and derived views
    csr_op_e                 op;
    logic                    wr_en;
    logic [31:0]             wr_val;
    logic [31:0]             csr_read;
    logic                    csr_hit;
    logic [31:0]             mstatus_val;
    logic [31:0]             mip_val;
    logic [NUM_PLAT_IRQ+1:0] irq_req;
    logic                    irq_valid;
    logic [4:0]              irq_code;
    logic                    trap_fire;
    logic                    mret_fire;
    logic [31:0]             trap_target;

    // Decode the CSR access; set/clear with a zero operand is treated as no write so counters keep running
    always_comb begin
        op    = csr_op_e'(csr_op);
        wr_en = (op == CSR_OP_WRITE) ||
                (((op == CSR_OP_SET) || (op == CSR_OP_CLEAR)) && (csr_wdata != 32'd0));
    end

    // Assemble the software-visible mstatus and mip words from their stored fields
    always_comb begin
        mstatus_val = 32'd0;
        mstatus_val[MSTATUS_MPP_LSB +: 2] = 2'b11;
        mstatus_val[MSTATUS_MIE_BIT]      = mstatus_mie_q;
        mstatus_val[MSTATUS_MPIE_BIT]     = mstatus_mpie_q;
        mip_val = 32'd0;
        mip_val[MIP_MTIP_BIT] = mtip_q;
        mip_val[MIP_MEIP_BIT] = meip_q;
        mip_val[MIP_PLAT_LSB +: NUM_PLAT_IRQ] = plat_q;
    end

    // Combinational read mux; unimplemented addresses read 0 and are flagged as misses
    always_comb begin
        csr_read = 32'd0;
        csr_hit  = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:  csr_read = mstatus_val;
            CSR_MIE:      csr_read = mie_q;
            CSR_MTVEC:    csr_read = mtvec_q;
            CSR_MSCRATCH: csr_read = mscratch_q;
            CSR_MEPC:     csr_read = mepc_q;
            CSR_MCAUSE:   csr_read = mcause_q;
            CSR_MIP:      csr_read = mip_val;
            CSR_MCYCLE:   csr_read = mcycle_q[31:0];
            CSR_MCYCLEH:  csr_read = mcycle_q[63:32];
            default:      csr_hit  = 1'b0;
        endcase
        wr_val = csr_apply(op, csr_read, csr_wdata);
    end

    // Enabled interrupt requests, all gated by the global MIE bit
    always_comb begin
        irq_req = {plat_q & mie_q[MIP_PLAT_LSB +: NUM_PLAT_IRQ],
                   meip_q & mie_q[MIP_MEIP_BIT],
                   mtip_q & mie_q[MIP_MTIP_BIT]} & {(NUM_PLAT_IRQ+2){mstatus_mie_q}};
    end

    csr_irq_arbiter #(
        .NUM_PLAT_IRQ(NUM_PLAT_IRQ)
    ) u_irq_arbiter (
        .pending(irq_req),
        .valid  (irq_valid),
        .code   (irq_code)
    );

    // Redirect decisions; mret beats a pending interrupt, and outputs are held quiet while reset is asserted
    always_comb begin
        mret_fire   = is_mret && trap_ready;
        trap_fire   = irq_valid && trap_ready && !is_mret;
        trap_target = mtvec_q & 32'hFFFF_FFFC;
        if (VECTORED_EN && mtvec_q[0]) begin
            trap_target = trap_target + {25'd0, irq_code, 2'b00};
        end
        trap_taken  = reset_n && trap_fire;
        redirect    = reset_n && (trap_fire || mret_fire);
        redirect_pc = 32'd0;
        if (reset_n && trap_fire) begin
            redirect_pc = trap_target;
        end else if (reset_n && mret_fire) begin
            redirect_pc = mepc_q;
        end
        csr_rdata   = csr_read;
        csr_illegal = reset_n && (op != CSR_OP_NONE) && !csr_hit;
    end

    // Next-state: CSR writes first, then trap entry or mret overrides the trap-owned fields
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtip_d         = mtip;
        meip_d         = meip;
        plat_d         = plat_irq;
        mcycle_d       = mcycle_q + 64'd1;

        if (wr_en) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = wr_val[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = wr_val[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_d      = wr_val & MIE_MASK;
                CSR_MTVEC:    mtvec_d    = wr_val & MTVEC_MASK;
                CSR_MSCRATCH: mscratch_d = wr_val;
                CSR_MEPC:     mepc_d     = wr_val & MEPC_MASK;
                CSR_MCAUSE:   mcause_d   = wr_val;
                CSR_MCYCLE:   mcycle_d   = {mcycle_q[63:32], wr_val};
                CSR_MCYCLEH:  mcycle_d   = {wr_val, mcycle_q[31:0]};
                default:      ;
            endcase
        end

        if (trap_fire) begin
            mepc_d         = pc & MEPC_MASK;
            mcause_d       = {1'b1, 26'd0, irq_code};
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_fire) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end

        if (!HAS_MCYCLE) begin
            mcycle_d = 64'd0;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'd0;
            mtvec_q        <= 32'd0;
            mscratch_q     <= 32'd0;
            mepc_q         <= 32'd0;
            mcause_q       <= 32'd0;
            mcycle_q       <= 64'd0;
            mtip_q         <= 1'b0;
            meip_q         <= 1'b0;
            plat_q         <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mcycle_q       <= mcycle_d;
            mtip_q         <= mtip_d;
            meip_q         <= meip_d;
            plat_q         <= plat_d;
        end
    end

endmodule
